truth_table_scanner: RTL and testbench

Sequential characterisation block that runs the inverse of a truth-table gate. A gate maps an input vector to an output bit; this block sweeps every input vector into a combinational device-under-test (DUT) and reads back the DUT's output bit for each one. The result is a captured truth table. It sits beside synthesised logic modules in the netlist flow and checks their functions against the intended truth table.

---
 rtl/truth_table_scanner.sv | 123 ++++++++++++
 tb/tb_truth_table_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - sweeps every input vector into a combinational DUT and captures its truth table (optional CHECK state: TT_SCAN_CONSISTENCY_EN)
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic [2**N_IN-1:0]   truth_table,
  output logic                 err
);

  // Vector counter is one bit wider than dut_in so the last-vector compare never wraps.
  localparam logic [N_IN:0] LAST_VEC    = {1'b0, {N_IN{1'b1}}};
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);

`ifdef TT_SCAN_CONSISTENCY_EN
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, CHECK, DONE} state_t;
  localparam state_t ADV_STATE = CHECK;
`else
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam state_t ADV_STATE = SAMPLE;
`endif

  state_t          state_q, state_d;
  logic [N_IN:0]   vec_q;
  logic [N_IN:0]   vec_next;
  logic [7:0]      cnt_q;
  logic            last_vec;

  assign vec_next = vec_q + 1'b1;
  assign last_vec = (vec_q == LAST_VEC);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; busy and done are pure state decodes.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
`ifdef TT_SCAN_CONSISTENCY_EN
        state_d = CHECK;
`else
        state_d = last_vec ? DONE : DRIVE;
`endif
      end
`ifdef TT_SCAN_CONSISTENCY_EN
      CHECK: begin
        busy    = 1'b1;
        state_d = last_vec ? DONE : DRIVE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: vector/settle counters, driven vector and captured table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q       <= '0;
      cnt_q       <= '0;
      dut_in      <= '0;
      truth_table <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        vec_q       <= '0;
        cnt_q       <= '0;
        dut_in      <= '0;
        truth_table <= '0;
      end
      if (state_q == DRIVE) cnt_q <= cnt_q + 8'd1;
      if (state_q == SAMPLE) truth_table[vec_q[N_IN-1:0]] <= dut_out;
      // dut_in only moves on the edge that re-enters DRIVE for the next vector.
      if (state_q == ADV_STATE && !last_vec) begin
        vec_q  <= vec_next;
        cnt_q  <= '0;
        dut_in <= vec_next[N_IN-1:0];
      end
    end
  end

`ifdef TT_SCAN_CONSISTENCY_EN
  logic err_q;

  // Sticky flag: the re-sample in CHECK disagrees with what SAMPLE captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      err_q <= 1'b0;
    end else if (state_q == CHECK && dut_out != truth_table[vec_q[N_IN-1:0]]) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - table-driven scoreboard bench for truth_table_scanner
`timescale 1ns/1ps
module tb_truth_table_scanner;

`ifdef TT_SCAN_CONSISTENCY_EN
  localparam int  PER_VEC   = 4;
  localparam int  PER_VEC_S = 3;
  localparam bit  TOGGLE_ERR = 1'b1;
`else
  localparam int  PER_VEC   = 3;
  localparam int  PER_VEC_S = 2;
  localparam bit  TOGGLE_ERR = 1'b0;
`endif
  localparam int LAT   = 1 + 8 * PER_VEC;
  localparam int LAT_S = 1 + 2 * PER_VEC_S;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, err;
  logic [2:0] dut_in;
  logic       dut_out;
  logic [7:0] tt;

  logic       start_s;
  logic       busy_s, done_s, err_s;
  logic [0:0] dut_in_s;
  logic       dut_out_s;
  logic [1:0] tt_s;

  int   func;
  logic toggle_bit = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    int         func;
    logic [7:0] exp_tt;
    string      name;
  } vec_t;

  truth_table_scanner #(.N_IN(3), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .dut_in(dut_in), .dut_out(dut_out), .truth_table(tt), .err(err)
  );

  truth_table_scanner #(.N_IN(1), .SETTLE(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .dut_in(dut_in_s), .dut_out(dut_out_s), .truth_table(tt_s), .err(err_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) toggle_bit <= ~toggle_bit;

  always_comb begin
    dut_out = 1'b0;
    case (func)
      0: dut_out = &dut_in;
      1: dut_out = dut_in[0];
      2: dut_out = |dut_in;
      3: dut_out = ^dut_in;
      4: dut_out = (dut_in == 3'd2) ? toggle_bit : &dut_in;
      default: dut_out = 1'b0;
    endcase
  end

  assign dut_out_s = ~dut_in_s[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input int f, input logic [7:0] exp_tt, input bit chk_tt,
                           input bit exp_err, input bit mid_pulse, input string name);
    int         cyc;
    int         bad;
    int         extra;
    bit         got;
    logic       clr_bad;
    logic [7:0] e;
    func = f;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.push_back(exp_tt);
    cyc = 0; bad = 0; got = 0; clr_bad = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mid_pulse) start = (cyc == 10);
      if (cyc == 1) clr_bad = (tt !== 8'h00);
      if (cyc < LAT && dut_in !== 3'((cyc - 1) / PER_VEC)) bad++;
      if (cyc < LAT && busy !== 1'b1) bad++;
      if (done === 1'b1) got = 1;
    end
    start = 1'b0;
    check({name, " done_latency"}, cyc, LAT);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({name, " dut_in_busy_seq"}, bad, 0);
    check({name, " table_cleared"}, {31'd0, clr_bad}, 32'd0);
    e = exp_q.pop_front();
    if (chk_tt) check({name, " table"}, {24'd0, tt}, {24'd0, e});
    check({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    if (mid_pulse) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) extra++;
      end
      check({name, " no_restart"}, extra, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[4];
    int   cyc;
    int   bad;
    logic [7:0] e;

    vecs[0] = '{0, 8'b1000_0000, "and3"};
    vecs[1] = '{1, 8'b1010_1010, "in1"};
    vecs[2] = '{2, 8'b1111_1110, "or3"};
    vecs[3] = '{3, 8'b1001_0110, "xor3"};

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; func = 0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset dut_in", {29'd0, dut_in}, 32'd0);
    check("reset table", {24'd0, tt}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_sweep(vecs[i].func, vecs[i].exp_tt, 1'b1, 1'b0, 1'b0, vecs[i].name);

    run_sweep(2, 8'b1111_1110, 1'b1, 1'b0, 1'b1, "or3_midpulse");

    // start held high: back-to-back sweeps, one IDLE cycle between them
    func = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'b1111_1110);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("held first latency", cyc, LAT);
    e = exp_q.pop_front();
    check("held first table", {24'd0, tt}, {24'd0, e});
    exp_q.push_back(8'b1111_1110);
    cyc = 0;
    bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 2 && tt !== 8'h00) bad++;
    end while (done !== 1'b1 && cyc < 300);
    start = 1'b0;
    check("held interval", cyc, LAT + 1);
    check("held table_cleared", bad, 0);
    e = exp_q.pop_front();
    check("held second table", {24'd0, tt}, {24'd0, e});
    repeat (3) @(negedge clk);
    check("held stops busy", {31'd0, busy}, 32'd0);

    // reset during vector 4 discards the partial table
    func = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (dut_in !== 3'd4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset reached vec4", {29'd0, dut_in}, 32'd4);
    check("midreset partial table", {24'd0, tt}, 32'h0a);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset dut_in", {29'd0, dut_in}, 32'd0);
    check("midreset table", {24'd0, tt}, 32'd0);
    check("midreset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, 8'b1000_0000, 1'b1, 1'b0, 1'b0, "after_reset_and3");

    // toggling DUT output on vector 2, then a clean sweep clears err
    run_sweep(4, 8'h00, 1'b0, TOGGLE_ERR, 1'b0, "toggle_v2");
    run_sweep(0, 8'b1000_0000, 1'b1, 1'b0, 1'b0, "clean_after_toggle");

    // N_IN=1, SETTLE=1 inverter
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    cyc = 0;
    while (done_s !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("small latency", cyc, LAT_S);
    check("small table", {30'd0, tt_s}, 32'b01);
    check("small err", {31'd0, err_s}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
